// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time over valid/ready and returns
// the word from a preloadable program RAM after a fixed LATENCY, with a misalignment/range error flag.
module imem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Unsigned wrap makes any address below BASE land far out of range.
  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && ((off >> 2) < DEPTH_W);
  endfunction

  function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_p0;
  logic        load;
  logic [31:0] rd_addr;
  logic        rd_ok;
  logic [IW-1:0] rd_idx;

  // With LATENCY==1 the read happens on the accept edge, so the live request address is used.
  assign rd_addr   = (state_q == IDLE) ? req_addr : addr_p0;
  assign rd_ok     = addr_ok(rd_addr);
  assign rd_idx    = addr_idx(rd_addr);
  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            load    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Preload port runs regardless of FSM state; reset blocks it.
  always_ff @(posedge clk) begin
    if (rst && wr_en && addr_ok(wr_addr)) mem[addr_idx(wr_addr)] <= wr_data;
  end

  // ---- stage p0: request capture and response register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_p0    <= 32'd0;
      resp_valid <= 1'b0;
      resp_inst  <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) addr_p0 <= req_addr;
      if (load) begin
        resp_valid <= 1'b1;
        if (rd_ok) begin
          resp_inst <= mem[rd_idx];
          resp_err  <= 1'b0;
        end else begin
          resp_inst <= 32'd0;
          resp_err  <= 1'b1;
        end
      end else if (state_q == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: main instance at LATENCY=2, plus LATENCY=1 and 7 instances
// for the latency/throughput sweep.
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;

  logic        sw_req_valid  [2];
  logic        sw_req_ready  [2];
  logic [31:0] sw_req_addr   [2];
  logic        sw_resp_valid [2];
  logic        sw_resp_ready [2];
  logic [31:0] sw_resp_inst  [2];
  logic        sw_resp_err   [2];
  logic        sw_wr_en      [2];
  logic [31:0] sw_wr_addr    [2];
  logic [31:0] sw_wr_data    [2];

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [int];
  int          checks = 0;
  int          errors = 0;

  imem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  imem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(sw_req_valid[0]), .req_ready(sw_req_ready[0]),
    .req_addr(sw_req_addr[0]), .resp_valid(sw_resp_valid[0]), .resp_ready(sw_resp_ready[0]),
    .resp_inst(sw_resp_inst[0]), .resp_err(sw_resp_err[0]), .wr_en(sw_wr_en[0]),
    .wr_addr(sw_wr_addr[0]), .wr_data(sw_wr_data[0]));

  imem_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(7)) dut_l7 (
    .clk(clk), .rst(rst), .req_valid(sw_req_valid[1]), .req_ready(sw_req_ready[1]),
    .req_addr(sw_req_addr[1]), .resp_valid(sw_resp_valid[1]), .resp_ready(sw_resp_ready[1]),
    .resp_inst(sw_resp_inst[1]), .resp_err(sw_resp_err[1]), .wr_en(sw_wr_en[1]),
    .wr_addr(sw_wr_addr[1]), .wr_data(sw_wr_data[1]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: 1024 words from 0x80000000, word-aligned only.
  function automatic exp_t expect_for(input logic [31:0] a);
    exp_t        e;
    logic [31:0] off;
    off = a - 32'h8000_0000;
    if (a[1:0] == 2'b00 && off < 32'd4096) begin
      e.inst = model_mem.exists(int'(off >> 2)) ? model_mem[int'(off >> 2)] : 32'h0;
      e.err  = 1'b0;
    end else begin
      e.inst = 32'h0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    off = a - 32'h8000_0000;
    if (a[1:0] == 2'b00 && off < 32'd4096) model_mem[int'(off >> 2)] = d;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model_write(a, d);
  endtask

  // Drives one request on the main instance and consumes its response.
  task automatic run_fetch(input logic [31:0] a, output int lat, output logic rdy_c1,
                           output logic [31:0] inst, output logic err);
    req_addr = a; req_valid = 1'b1; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    rdy_c1 = req_ready;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (resp_valid) begin
        lat = i;
        break;
      end
      tick();
    end
    inst = resp_inst; err = resp_err;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      sw_req_valid[k] = 1'b0; sw_req_addr[k] = 32'd0; sw_resp_ready[k] = 1'b0;
      sw_wr_en[k] = 1'b0; sw_wr_addr[k] = 32'd0; sw_wr_data[k] = 32'd0;
    end
    tick();
    do_write(32'h8000_0000, 32'h0000_0413);
    do_write(32'h8000_0004, 32'h1111_1111);
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h8000_0004; wr_data = 32'h2222_2222;
    tick();
    wr_en = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b need=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b need=1", req_ready); end
    checks++; if (resp_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h need=0", resp_inst); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b need=0", resp_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] addrs [2];
    int lat; logic rdy; logic [31:0] inst; logic err; exp_t e;
    addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0004;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(expect_for(addrs[i]));
      run_fetch(addrs[i], lat, rdy, inst, err);
      e = sb.pop_front();
      checks++; if (inst !== e.inst || err !== e.err) begin errors++;
        $display("FAIL basic_data addr=%h got=%h/%b need=%h/%b", addrs[i], inst, err, e.inst, e.err); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got=%0d need=2", lat); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_busy_ready got=%b need=0", rdy); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic got;
    sb.push_back(expect_for(32'h8000_0004));
    req_addr = 32'h8000_0004; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) begin got = 1'b1; break; end
      tick();
    end
    e = sb.pop_front();
    checks++; if (!got || resp_inst !== e.inst || resp_err !== e.err) begin errors++;
      $display("FAIL bp_first valid=%b got=%h need=%h", got, resp_inst, e.inst); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_inst !== e.inst || req_ready !== 1'b0) begin errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b inst=%h ready=%b need 1/%h/0", i, resp_valid, resp_inst, req_ready, e.inst); end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b need=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b need=1", req_ready); end
    checks++; if (resp_inst !== e.inst) begin errors++; $display("FAIL bp_inst_kept got=%h need=%h", resp_inst, e.inst); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    int lat; logic rdy; logic [31:0] inst; logic err; exp_t e;
    addrs[0] = 32'h8000_0002; addrs[1] = 32'h7FFF_FFFC; addrs[2] = 32'h8000_1000;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(expect_for(addrs[i]));
      run_fetch(addrs[i], lat, rdy, inst, err);
      e = sb.pop_front();
      checks++; if (err !== e.err || inst !== e.inst) begin errors++;
        $display("FAIL err_fetch addr=%h got=%h/%b need=%h/%b", addrs[i], inst, err, e.inst, e.err); end
    end
    // Misaligned and out-of-range writes must leave word 0 untouched.
    do_write(32'h8000_0002, 32'hFFFF_FFFF);
    do_write(32'h8000_1000, 32'hEEEE_EEEE);
    sb.push_back(expect_for(32'h8000_0000));
    run_fetch(32'h8000_0000, lat, rdy, inst, err);
    e = sb.pop_front();
    checks++; if (inst !== e.inst || err !== e.err) begin errors++;
      $display("FAIL err_write_dropped got=%h/%b need=%h/%b", inst, err, e.inst, e.err); end
  endtask

  task automatic test_collision();
    int lat; logic rdy; logic [31:0] inst; logic err; exp_t e;
    do_write(32'h8000_000C, 32'hAAAA_AAAA);
    sb.push_back(expect_for(32'h8000_000C));
    req_addr = 32'h8000_000C; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h8000_000C; wr_data = 32'hBBBB_BBBB;
    tick();
    wr_en = 1'b0;
    model_write(32'h8000_000C, 32'hBBBB_BBBB);
    e = sb.pop_front();
    checks++; if (resp_valid !== 1'b1 || resp_inst !== e.inst) begin errors++;
      $display("FAIL collide_old valid=%b got=%h need=1/%h", resp_valid, resp_inst, e.inst); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    sb.push_back(expect_for(32'h8000_000C));
    run_fetch(32'h8000_000C, lat, rdy, inst, err);
    e = sb.pop_front();
    checks++; if (inst !== e.inst || err !== e.err) begin errors++;
      $display("FAIL collide_refetch got=%h need=%h", inst, e.inst); end
  endtask

  task automatic test_reset_inflight();
    int seen;
    req_addr = 32'h8000_0000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL inflight_valid got=%b need=0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL inflight_ready got=%b need=1", req_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL inflight_ghost got=%0d need=0", seen); end
  endtask

  task automatic test_latency_sweep(input int k, input int L);
    int P; int acc [$]; int rsp [$];
    logic [31:0] v1, v2, ev; logic [31:0] exp_q [$]; logic got;
    P = L + 1;
    v1 = 32'h1000_0000 + 32'(L);
    v2 = 32'h2000_0000 + 32'(L);
    sw_wr_en[k] = 1'b1; sw_wr_addr[k] = 32'h8000_0010; sw_wr_data[k] = v1;
    tick();
    sw_wr_en[k] = 1'b0;
    if (L > 2) begin
      // Write lands while the request is still waiting, so the response must see it.
      sw_req_addr[k] = 32'h8000_0010; sw_req_valid[k] = 1'b1;
      tick();
      sw_req_valid[k] = 1'b0;
      tick();
      sw_wr_en[k] = 1'b1; sw_wr_data[k] = v2;
      tick();
      sw_wr_en[k] = 1'b0;
      v1 = v2;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (sw_resp_valid[k]) begin got = 1'b1; break; end
        tick();
      end
      checks++; if (!got || sw_resp_inst[k] !== v2) begin errors++;
        $display("FAIL sweep_wait_write L=%0d valid=%b got=%h need=%h", L, got, sw_resp_inst[k], v2); end
      sw_resp_ready[k] = 1'b1;
      tick();
      sw_resp_ready[k] = 1'b0;
    end
    sw_req_addr[k] = 32'h8000_0010; sw_resp_ready[k] = 1'b1;
    for (int cyc = 0; cyc < 3 * P; cyc++) begin
      sw_req_valid[k] = (cyc <= 2 * P);
      if (sw_req_valid[k] && sw_req_ready[k]) begin
        acc.push_back(cyc);
        exp_q.push_back(v1);
      end
      if (sw_resp_valid[k]) begin
        rsp.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL sweep_extra_resp L=%0d cyc=%0d", L, cyc); end
        else begin
          ev = exp_q.pop_front();
          if (sw_resp_inst[k] !== ev || sw_resp_err[k] !== 1'b0) begin errors++;
            $display("FAIL sweep_data L=%0d got=%h/%b need=%h/0", L, sw_resp_inst[k], sw_resp_err[k], ev); end
        end
      end
      tick();
    end
    sw_req_valid[k] = 1'b0; sw_resp_ready[k] = 1'b0;
    checks++; if (acc.size() != 3) begin errors++; $display("FAIL sweep_accepts L=%0d got=%0d need=3", L, acc.size()); end
    checks++; if (rsp.size() != 3) begin errors++; $display("FAIL sweep_resps L=%0d got=%0d need=3", L, rsp.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= acc.size() || i >= rsp.size()) begin errors++;
        $display("FAIL sweep_timing L=%0d idx=%0d missing", L, i); end
      else if (acc[i] != i * P || rsp[i] != acc[i] + L) begin errors++;
        $display("FAIL sweep_timing L=%0d idx=%0d accept=%0d resp=%0d need %0d/%0d", L, i, acc[i], rsp[i], i * P, i * P + L); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_collision();
    test_reset_inflight();
    test_latency_sweep(0, 1);
    test_latency_sweep(1, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
